// File: rtl/tt_um_priority_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tt_um_priority_decoder
// Brief    : 16-bit one-hot decoder (inverse of the priority encoder tile)
//            with sequenced sweep-up, sweep-down and freeze modes driven by
//            a prescaled step timer.
// Revision : 1.0 - initial release
// ============================================================================
module tt_um_priority_decoder #(
    parameter int STEP_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // Prescaler must be at least one bit wide even when STEP_DIV == 1.
    localparam int              C_PW   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [C_PW-1:0] C_TERM = C_PW'(STEP_DIV - 1);
    localparam logic [C_PW-1:0] C_ONE  = C_PW'(1);

    localparam logic [3:0] C_OP_LOAD   = 4'h0;
    localparam logic [3:0] C_OP_UP     = 4'h1;
    localparam logic [3:0] C_OP_DOWN   = 4'h2;
    localparam logic [3:0] C_OP_FREEZE = 4'h3;
    localparam logic [3:0] C_OP_NONE   = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UP     = 2'd1,
        S_DOWN   = 2'd2,
        S_FROZEN = 2'd3
    } state_t;

    logic [7:0]      r_ui_q;
    logic            r_chg;
    state_t          r_state;
    logic [3:0]      r_pos;
    logic [C_PW-1:0] r_pres;
    logic            r_blank;
    logic [15:0]     r_out;

    state_t          w_state;
    logic [3:0]      w_pos;
    logic [C_PW-1:0] w_pres;
    logic            w_blank;
    logic [3:0]      w_op;
    logic [3:0]      w_idx;
    logic            w_unused;

    assign w_op     = r_ui_q[7:4];
    assign w_idx    = r_ui_q[3:0];
    assign w_unused = &{1'b0, ena, uio_in};

    // Next-state: free-running sweep step first, then command overrides.
    always_comb begin
        w_state = r_state;
        w_pos   = r_pos;
        w_pres  = r_pres;
        w_blank = r_blank;

        case (r_state)
            S_UP, S_DOWN: begin
                if (r_pres == C_TERM) begin
                    w_pres = '0;
                    w_pos  = (r_state == S_UP) ? r_pos + 4'd1 : r_pos - 4'd1;
                end else begin
                    w_pres = r_pres + C_ONE;
                end
            end
            default: ;
        endcase

        // r_chg pairs with r_ui_q: it says whether the command now being
        // decoded differed from the one sampled before it.
        if (w_op == C_OP_LOAD) begin
            w_state = S_IDLE;
            w_pos   = w_idx;
            w_pres  = '0;
            w_blank = 1'b0;
        end else if (w_op == C_OP_NONE) begin
            w_state = S_IDLE;
            w_pos   = r_pos;
            w_pres  = '0;
            w_blank = 1'b1;
        end else if ((w_op == C_OP_UP || w_op == C_OP_DOWN) && r_chg) begin
            w_state = (w_op == C_OP_UP) ? S_UP : S_DOWN;
            w_pos   = w_idx;
            w_pres  = '0;
            w_blank = 1'b0;
        end else if (w_op == C_OP_FREEZE && r_chg) begin
            w_state = S_FROZEN;
            w_pos   = r_pos;
            w_pres  = r_pres;
        end
    end

    // Input sampling, sequencer state and the registered one-hot output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ui_q  <= 8'hF0;
            r_chg   <= 1'b0;
            r_state <= S_IDLE;
            r_pos   <= 4'd0;
            r_pres  <= '0;
            r_blank <= 1'b1;
            r_out   <= 16'h0000;
        end else begin
            r_ui_q  <= ui_in;
            r_chg   <= (ui_in != r_ui_q);
            r_state <= w_state;
            r_pos   <= w_pos;
            r_pres  <= w_pres;
            r_blank <= w_blank;
            r_out   <= w_blank ? 16'h0000 : (16'(1) << w_pos);
        end
    end

    assign uo_out  = r_out[15:8];
    assign uio_out = r_out[7:0];
    assign uio_oe  = 8'hFF;

endmodule
`default_nettype wire

// File: tb/tb_tt_um_priority_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_tt_um_priority_decoder
// Brief    : Self-checking bench for tt_um_priority_decoder; two instances
//            (STEP_DIV 4 and 1) compared against a time-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tt_um_priority_decoder;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo4, uio4, oe4;
    logic [7:0] uo1, uio1, oe1;
    logic [15:0] out4, out1;

    int n_tests;
    int n_fail;

    assign out4 = {uo4, uio4};
    assign out1 = {uo1, uio1};

    tt_um_priority_decoder #(.STEP_DIV(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo4), .uio_out(uio4), .uio_oe(oe4)
    );

    tt_um_priority_decoder #(.STEP_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo1), .uio_out(uio1), .uio_oe(oe1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: position is a function of time since sweep entry
    // (base +/- elapsed/STEP_DIV mod 16); idle/frozen hold a fixed value.
    // Index 0 models STEP_DIV=4, index 1 models STEP_DIV=1.
    // ------------------------------------------------------------------
    int         m_mode [2];   // 0 idle, 1 up, 2 down, 3 frozen
    int         m_base [2];
    int         m_t0   [2];
    int         m_hold [2];
    bit         m_blank[2];
    int         m_n;
    logic [7:0] m_a1, m_a2;   // inputs sampled at the last two edges

    function automatic int sdiv(int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic int pos_at(int d, int m);
        int q;
        q = (m - m_t0[d]) / sdiv(d);
        case (m_mode[d])
            1:       return (m_base[d] + q) % 16;
            2:       return (((m_base[d] - q) % 16) + 16) % 16;
            default: return m_hold[d];
        endcase
    endfunction

    function automatic logic [15:0] m_exp(int d);
        if (m_blank[d]) return 16'h0000;
        return 16'(1) << pos_at(d, m_n);
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = 0; m_base[d] = 0; m_t0[d] = 0;
            m_hold[d] = 0; m_blank[d] = 1'b1;
        end
        m_n  = 0;
        m_a1 = 8'hF0;
        m_a2 = 8'hF0;
    endfunction

    function automatic void model_step(logic [7:0] v);
        bit         chg;
        logic [3:0] op, idx;
        int         cur;
        chg = (m_a1 != m_a2);
        op  = m_a1[7:4];
        idx = m_a1[3:0];
        m_n = m_n + 1;
        for (int d = 0; d < 2; d++) begin
            cur = pos_at(d, m_n - 1);
            if (op == 4'h0) begin
                m_mode[d] = 0; m_hold[d] = int'(idx); m_blank[d] = 1'b0;
            end else if (op == 4'hF) begin
                m_mode[d] = 0; m_hold[d] = cur; m_blank[d] = 1'b1;
            end else if ((op == 4'h1 || op == 4'h2) && chg) begin
                m_mode[d] = int'(op); m_base[d] = int'(idx);
                m_t0[d] = m_n; m_blank[d] = 1'b0;
            end else if (op == 4'h3 && chg) begin
                m_mode[d] = 3; m_hold[d] = cur;
            end
        end
        m_a2 = m_a1;
        m_a1 = v;
    endfunction

    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Apply v, take one edge, check both instances against the model.
    task automatic tick(input logic [7:0] v);
        ui_in = v;
        @(posedge clk);
        model_step(v);
        #1;
        chk("model_sd4", out4, m_exp(0));
        chk("model_sd1", out1, m_exp(1));
    endtask

    task automatic ticks(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) tick(v);
    endtask

    initial begin
        logic [3:0] op;
        logic [7:0] v;
        n_tests = 0;
        n_fail  = 0;
        ena     = 1'b1;
        uio_in  = 8'h00;
        ui_in   = 8'h00;
        rst_n   = 1'b0;
        model_reset();
        #12;
        chk("reset_out4", out4, 16'h0000);
        chk("reset_out1", out1, 16'h0000);
        chk("reset_oe", {oe4, oe1}, 16'hFFFF);
        rst_n = 1'b1;

        // Basic LOAD with two-edge latency
        tick(8'h05);
        tick(8'h05);
        chk("load05", out4, 16'h0020);

        // Round trip of every encoder code, then "no ones"
        for (int k = 0; k < 16; k++) begin
            ticks(8'(k), 2);
            chk("roundtrip", out4, 16'(1) << k);
        end
        ticks(8'hF0, 2);
        chk("none_f0", out4, 16'h0000);

        // Sweep up from 14 with wrap; static hold never restarts
        ticks(8'h1E, 2);
        chk("up_start", out4, 16'h4000);
        chk("up_start_sd1", out1, 16'h4000);
        ticks(8'h1E, 4);
        chk("up_step", out4, 16'h8000);
        ticks(8'h1E, 4);
        chk("up_wrap", out4, 16'h0001);
        ticks(8'h1E, 40);
        chk("up_static", out4, 16'h0400);

        // Sweep down from 1, wrap, freeze, then LOAD
        ticks(8'h21, 2);
        chk("dn_start", out4, 16'h0002);
        ticks(8'h21, 4);
        chk("dn_step", out4, 16'h0001);
        ticks(8'h21, 4);
        chk("dn_wrap", out4, 16'h8000);
        ticks(8'h30, 2);
        for (int i = 0; i < 50; i++) begin
            tick(8'h30);
            chk("frozen", out4, 16'h8000);
        end
        ticks(8'h07, 2);
        chk("unfreeze_load", out4, 16'h0080);

        // Reserved opcode is ignored
        ticks(8'h03, 2);
        chk("load03", out4, 16'h0008);
        for (int i = 0; i < 3; i++) begin
            tick(8'h47);
            chk("reserved", out4, 16'h0008);
        end

        // Randomised command segments
        for (int s = 0; s < 60; s++) begin
            case ($urandom_range(0, 6))
                0:       op = 4'h0;
                1:       op = 4'h1;
                2:       op = 4'h2;
                3:       op = 4'h3;
                4:       op = 4'hF;
                5:       op = 4'($urandom_range(4, 14));
                default: op = 4'h1;
            endcase
            v = {op, 4'($urandom_range(0, 15))};
            ticks(v, $urandom_range(1, 12));
        end

        // Asynchronous reset mid-sweep, release with a sweep command held
        ticks(8'h25, 7);
        ui_in = 8'h1A;
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst4", out4, 16'h0000);
        chk("async_rst1", out1, 16'h0000);
        model_reset();
        #1;
        rst_n = 1'b1;
        ticks(8'h1A, 2);
        chk("rst_restart4", out4, 16'h0400);
        chk("rst_restart1", out1, 16'h0400);
        ticks(8'h1A, 12);
        chk("end_oe", {oe4, oe1}, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
